// File: rtl/stack_lifo_if.sv
// Handshake and status bundle for the LIFO stack.
// master: the client that pushes and pops. slave: the stack itself.
interface stack_lifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, din,
    input  dout, valid, full, empty, count, ovf, unf
  );

  modport slave (
    input  push, pop, din,
    output dout, valid, full, empty, count, ovf, unf
  );
endinterface

// File: rtl/stack_lifo.sv
// Synchronous LIFO stack: DEPTH-word register file, count-as-stack-pointer,
// registered pop data with a one-cycle valid pulse, and sticky
// overflow/underflow flags. Push+Pop together swaps the top word, or
// bypasses Din straight to Dout when the stack is empty.
module stack_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        clr,
  stack_lifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             ovf_q;
  logic             unf_q;

  logic             full;
  logic             empty;
  logic [CW-1:0]    top_ptr;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count_nxt;
  logic             set_ovf;
  logic             set_unf;

  // Count is the stack pointer; the top word lives one slot below it.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign top_ptr = count_q - CW'(1);

  // Decode the requested operation against the current fill level.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    rd_en     = 1'b0;
    rd_data   = '0;
    count_nxt = count_q;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = count_q[AW-1:0];
          count_nxt = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          rd_en     = 1'b1;
          rd_data   = mem[top_ptr[AW-1:0]];
          count_nxt = top_ptr;
        end
      end
      2'b11: begin
        // Swap replaces the top in place, so a full stack cannot overflow here.
        rd_en = 1'b1;
        if (empty) begin
          rd_data = bus.din;
        end else begin
          rd_data   = mem[top_ptr[AW-1:0]];
          mem_we    = 1'b1;
          mem_waddr = top_ptr[AW-1:0];
        end
      end
      default: ;
    endcase
  end

  // Storage array: never cleared, contents are meaningless past Count.
  always_ff @(posedge clk) begin
    if (!clr && mem_we) begin
      mem[mem_waddr] <= bus.din;
    end
  end

  // Pointer, output data and sticky flags; clear discards any pending op.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      valid_q <= rd_en;
      if (rd_en) begin
        dout_q <= rd_data;
      end
      if (set_ovf) begin
        ovf_q <= 1'b1;
      end
      if (set_unf) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: doc/stack_lifo.md
# stack_lifo

Synchronous LIFO stack built on the team's edge-triggered D flip-flop storage: a register file of DEPTH words, a stack pointer, full/empty/count status and sticky error flags. It sits downstream of the flip-flop primitives and upstream of any consumer needing last-in-first-out buffering, for example expression evaluation or return-address storage. All state changes on the rising edge of Clk. Dout is registered.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 8, number of storage words (≥2); CW = clog2(DEPTH+1)
- Clk  in  1  rising-edge clock, the only clock
- Clr  in  1  synchronous reset, active-high, sampled on rising Clk
- Push  in  1  write Din onto top of stack this cycle
- Pop  in  1  remove top word this cycle; word appears on Dout next cycle
- Din  in  WIDTH  push data
- Dout  out  WIDTH  registered popped word; holds its value when Valid=0
- Valid  out  1  one-cycle pulse: Dout updated by a pop this cycle
- Full  out  1  Count == DEPTH (combinational from Count)
- Empty  out  1  Count == 0 (combinational from Count)
- Count  out  CW  number of stored words, 0..DEPTH
- Ovf  out  1  sticky: push attempted while full
- Unf  out  1  sticky: pop attempted while empty

## Operation
- Storage mem[0..DEPTH-1]; pointer sp = Count; top word = mem[sp-1].
- Clr=1 at an edge: Count=0, Dout=0, Valid=0, Ovf=0, Unf=0. Clr overrides Push/Pop in the same cycle. Storage contents are not cleared and are don't-care.
- The following rules apply at each edge with Clr=0, according to {Push,Pop} and state:
- 00: nothing changes; Valid=0.
- 10, not full: mem[sp]=Din, Count+1, Valid=0.
- 10, full: push dropped, storage and Count unchanged, Ovf=1, Valid=0.
- 01, not empty: Dout=mem[sp-1], Count-1, Valid=1.
- 01, empty: no change to Dout or Count, Unf=1, Valid=0.
- 11, not empty (including full): swap. Dout=mem[sp-1] (old top), mem[sp-1]=Din, Count unchanged, Valid=1. No Ovf, even when full.
- 11, empty: bypass. Dout=Din, Count stays 0, Valid=1. No Unf.
- Ovf and Unf stay at 1 until Clr. They never clear on a later legal operation.
- Count never exceeds DEPTH and never wraps below 0. Pointer arithmetic is CW bits wide with no modular wrap.
- No state machine beyond the Count register. Full and Empty are decoded from Count and change in the same cycle Count changes.

## Timing
- Push latency: a word pushed at edge N can be popped at edge N+1, which puts it on Dout after edge N+1.
- Pop latency: 1 cycle. Pop sampled at edge N gives Dout/Valid valid after edge N, for the cycle N..N+1.
- Back-to-back pops at every edge are allowed. Valid stays high continuously while the stack is non-empty.
- Status outputs (Full, Empty, Count) reflect state after the most recent edge. There is no lookahead.
- Reset takes effect at the first rising Clk with Clr=1. A push or pop in progress in that cycle is discarded. Outputs are at reset values from that edge onward.
- There is no combinational path from Push, Pop or Din to any output.

## Test plan
- Reset: hold Clr=1 for 2 cycles with Push=1. Require Count=0, Empty=1, Full=0, Dout=0, Valid=0, Ovf=Unf=0.
- LIFO order: push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times. Require Dout sequence 0x33, 0x22, 0x11 with Valid high for 3 cycles, then Count=0 and Empty=1.
- Overflow: push 0x01..0x08 so that Full=1 and Count=8, then push 0xFF. Require Ovf=1, Count=8, and a following pop returns 0x08, not 0xFF. Ovf stays 1 through 8 pops until Clr.
- Underflow: with the stack empty, assert Pop. Require Unf=1, Valid=0, Dout unchanged, Count=0. Then push 0x5A and pop: Dout=0x5A, Valid=1, Unf still 1.
- Simultaneous: push 0xA0, then Push+Pop with Din=0xB0. Require Dout=0xA0, Valid=1, Count=1. A following pop returns 0xB0. With the stack empty, Push+Pop with Din=0xC3 gives Dout=0xC3, Valid=1, Count=0, Unf=0.
- Reset mid-operation: push 3 words, then assert Clr in the same cycle as Pop=1. Require Valid=0, Dout=0, Count=0 after that edge, and a subsequent pop sets Unf=1.
